// File: rtl/rotate_pipe_if.sv
// Operand/result handshake bundle for rotate_pipe.
// The master side drives operands and out_ready; the slave side is the pipeline.
interface rotate_pipe_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [1:0]       in_mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_amt, in_mode, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_amt, in_mode, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/rotate_pipe.sv
// Pipelined log-shifter: SHW registered stages, stage k displaces by 2^k.
// Define ROTATE_PIPE_SHIFT_EN to add zero-fill SHR/SHL; otherwise mode[1] is ignored.
module rotate_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic         clk,
  input  logic         rst,
  rotate_pipe_if.slave bus
);

`ifdef ROTATE_PIPE_SHIFT_EN
  localparam int MW = 2;
`else
  localparam int MW = 1;
`endif

  logic [SHW-1:0]   valid_q, valid_d;
  logic [WIDTH-1:0] data_q [SHW];
  logic [WIDTH-1:0] data_d [SHW];
  logic [SHW-1:0]   amt_q  [SHW];
  logic [SHW-1:0]   amt_d  [SHW];
  logic [MW-1:0]    mode_q [SHW];
  logic [MW-1:0]    mode_d [SHW];

  logic [SHW-1:0]   src_valid;
  logic [WIDTH-1:0] src_data [SHW];
  logic [SHW-1:0]   src_amt  [SHW];
  logic [MW-1:0]    src_mode [SHW];

  logic          stall;
  logic          accept;
  logic [MW-1:0] mode_in;

`ifdef ROTATE_PIPE_SHIFT_EN
  assign mode_in = bus.in_mode;

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x,
                                            input logic [MW-1:0]    m,
                                            input int unsigned      s);
    case (m)
      2'b00:   step = (x >> s) | (x << (WIDTH - s));
      2'b01:   step = (x << s) | (x >> (WIDTH - s));
      2'b10:   step = x >> s;
      default: step = x << s;
    endcase
  endfunction
`else
  logic unused_mode_hi;
  assign unused_mode_hi = bus.in_mode[1];
  assign mode_in        = bus.in_mode[0];

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x,
                                            input logic [MW-1:0]    m,
                                            input int unsigned      s);
    step = m[0] ? ((x << s) | (x >> (WIDTH - s)))
                : ((x >> s) | (x << (WIDTH - s)));
  endfunction
`endif

  // Whole pipeline freezes only when the output word is held by the consumer.
  assign stall         = valid_q[SHW-1] && !bus.out_ready;
  assign bus.in_ready  = !stall && !rst;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_data  = data_q[SHW-1];
  assign bus.out_valid = valid_q[SHW-1];

  always_comb begin
    src_valid[0] = accept;
    src_data[0]  = bus.in_data;
    src_amt[0]   = bus.in_amt;
    src_mode[0]  = mode_in;
    for (int unsigned k = 1; k < SHW; k++) begin
      src_valid[k] = valid_q[k-1];
      src_data[k]  = data_q[k-1];
      src_amt[k]   = amt_q[k-1];
      src_mode[k]  = mode_q[k-1];
    end

    valid_d = valid_q;
    data_d  = data_q;
    amt_d   = amt_q;
    mode_d  = mode_q;
    if (!stall) begin
      for (int unsigned k = 0; k < SHW; k++) begin
        valid_d[k] = src_valid[k];
        // Payload loads only with a valid word so out_data holds across bubbles.
        if (src_valid[k]) begin
          data_d[k] = src_amt[k][k] ? step(src_data[k], src_mode[k], 1 << k)
                                    : src_data[k];
          amt_d[k]  = src_amt[k];
          mode_d[k] = src_mode[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int unsigned k = 0; k < SHW; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      mode_q  <= mode_d;
    end
  end

endmodule

// File: tb/tb_rotate_pipe.sv
// Directed bench for rotate_pipe at WIDTH=32; expectations follow ROTATE_PIPE_SHIFT_EN.
module tb_rotate_pipe;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  rotate_pipe_if #(.WIDTH(32)) bus ();

  rotate_pipe #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef ROTATE_PIPE_SHIFT_EN
  localparam logic [31:0] EXP_SHR31 = 32'h0000_0001;
  localparam logic [31:0] EXP_SHL31 = 32'h8000_0000;
  localparam logic [31:0] EXP_SHR4  = 32'h0F00_0000;
  localparam logic [31:0] EXP_SHL4  = 32'h0000_00F0;
`else
  localparam logic [31:0] EXP_SHR31 = 32'h0000_0003;
  localparam logic [31:0] EXP_SHL31 = 32'hC000_0000;
  localparam logic [31:0] EXP_SHR4  = 32'hFF00_0000;
  localparam logic [31:0] EXP_SHL4  = 32'h0000_00FF;
`endif

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Single operand, idle pipe: checks latency (acceptance edge counts as 1) and result.
  task automatic run_one(input string tag, input logic [31:0] d, input logic [4:0] a,
                         input logic [1:0] m, input logic [31:0] exp);
    int cyc = 0;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_amt    = a;
    bus.in_mode   = m;
    bus.out_ready = 1'b1;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        bus.in_amt   = 5'($urandom);
      end
    end while (!bus.out_valid && cyc < 20);
    check_eq({tag, " latency"}, 64'(cyc), 64'd5);
    check_eq({tag, " data"}, 64'(bus.out_data), 64'(exp));
  endtask

  logic [31:0] sd [5] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_FFFF, 32'hA5A5_A5A5, 32'h1234_5678};
  logic [4:0]  sa [5] = '{5'd1, 5'd1, 5'd16, 5'd4, 5'd28};
  logic [1:0]  sm [5] = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
  logic [31:0] se [5] = '{32'h0000_0002, 32'h8000_0000, 32'hFFFF_0000, 32'h5A5A_5A5A, 32'h8123_4567};

  initial begin
    int sent, got, stale;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_mode   = '0;
    bus.out_ready = 1'b1;

    @(negedge clk);
    #1;
    check_eq("rst in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    check_eq("rst out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst out_data", 64'(bus.out_data), 64'd0);
    rst = 1'b0;
    #1;
    check_eq("idle in_ready", 64'(bus.in_ready), 64'd1);

    run_one("rotr1", 32'h8000_0001, 5'd1, 2'b00, 32'hC000_0000);
    run_one("rotl4", 32'h8000_0001, 5'd4, 2'b01, 32'h0000_0018);
    for (int m = 0; m < 4; m++)
      run_one($sformatf("amt0 m%0d", m), 32'hDEAD_BEEF, 5'd0, 2'(m), 32'hDEAD_BEEF);
    run_one("shr31", 32'h8000_0001, 5'd31, 2'b10, EXP_SHR31);
    run_one("shl31", 32'h8000_0001, 5'd31, 2'b11, EXP_SHL31);
    run_one("rotr8", 32'h1234_5678, 5'd8, 2'b00, 32'h7812_3456);
    run_one("rotl12", 32'h1234_5678, 5'd12, 2'b01, 32'h4567_8123);
    run_one("shr4", 32'hF000_000F, 5'd4, 2'b10, EXP_SHR4);
    run_one("shl4", 32'hF000_000F, 5'd4, 2'b11, EXP_SHL4);

    @(negedge clk);
    @(negedge clk);
    check_eq("hold out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("hold out_data", 64'(bus.out_data), 64'(EXP_SHL4));

    // Back-to-back stream with the consumer stalling in cycles 6..8.
    sent = 0;
    got  = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.out_ready = !(c >= 6 && c <= 8);
      if (sent < 5) begin
        bus.in_valid = 1'b1;
        bus.in_data  = sd[sent];
        bus.in_amt   = sa[sent];
        bus.in_mode  = sm[sent];
      end else begin
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        bus.in_amt   = 5'($urandom);
        bus.in_mode  = 2'($urandom);
      end
      #1;
      if (c < 14)
        check_eq($sformatf("stall in_ready c%0d", c), 64'(bus.in_ready),
                 64'(!(c >= 6 && c <= 8)));
      if (bus.in_valid && bus.in_ready) sent++;
      if (bus.out_valid && bus.out_ready) begin
        if (got < 5) check_eq($sformatf("stream data %0d", got), 64'(bus.out_data), 64'(se[got]));
        got++;
      end
    end
    check_eq("stream sent", 64'(sent), 64'd5);
    check_eq("stream got", 64'(got), 64'd5);

    // Reset with three operands in flight and a fourth offered during reset.
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = sd[c];
      bus.in_amt   = sa[c];
      bus.in_mode  = sm[c];
      if (c == 3) begin
        rst = 1'b1;
        #1;
        check_eq("mid rst in_ready", 64'(bus.in_ready), 64'd0);
      end
    end
    @(posedge clk);
    #1;
    check_eq("mid rst out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("mid rst out_data", 64'(bus.out_data), 64'd0);
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    stale        = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    check_eq("no stale result", 64'(stale), 64'd0);
    run_one("post rst", 32'h0000_00F0, 5'd4, 2'b00, 32'h0000_000F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
